// File: rtl/phy_clk_sel_pkg.sv
// Shared types and widths for the PHY clock-select sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package phy_clk_sel_pkg;

    localparam int CNT_W = 8;   // sequencing down-counter width
    localparam int SEL_W = 2;   // clock-mux select width (4 sources)

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_GATE_OFF = 3'd2,
        ST_SWITCH   = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_ACK      = 3'd5
    } state_e;

endpackage

// File: rtl/phy_clk_sel_cnt.sv
// Loadable down-counter that saturates at zero; flags when the next count is zero.
// Latency: count registered; zero is combinational on the value being loaded into the register.
// Backpressure: none; load takes priority over decrement.
//
// Ports:
//   clk, reset      : clock and synchronous active-high reset (count <= RST_VAL)
//   load, load_val  : load a new count
//   dec             : decrement by one (holds at zero)
//   zero            : next count value is zero
module phy_clk_sel_cnt
    import phy_clk_sel_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = CNT_W'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Flagging the next value lets the FSM leave a timed state on the same
    // edge the count reaches zero, so a load of N gives exactly N cycles.
    assign zero = (cnt_d == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phy_clk_sel_seq.sv
// Glitch-free clock-source switch sequencer: gate ICG off, move mux select, settle, re-enable.
// Latency: real switch sel moves GATE_OFF_CYC+1 and sel_ack fires GATE_OFF_CYC+SETTLE_CYC+2 cycles after sampling; no-op/reject acks 1 cycle after sampling.
// Backpressure: requester holds sel_req_vld until sel_ack; requests only sampled in IDLE, never in the cycle right after an ack.
//
// Ports:
//   clk, reset        : always-on reference clock, synchronous active-high reset
//   sel_req_vld/sel_req : level request and wanted source index
//   clk_ok            : per-source alive flags (already synchronised)
//   sel               : registered mux select
//   clk_gate_en       : registered ICG enable after the mux
//   sel_ack/sel_err   : one-cycle completion pulse / rejection-or-fault flag with it
//   busy              : high whenever the sequencer is not idle
module phy_clk_sel_seq
    import phy_clk_sel_pkg::*;
#(
    parameter int unsigned      GATE_OFF_CYC = 4,
    parameter int unsigned      SETTLE_CYC   = 8,
    parameter logic [SEL_W-1:0] DEFAULT_SEL  = 2'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel_req_vld,
    input  logic [SEL_W-1:0] sel_req,
    input  logic [3:0]       clk_ok,
    output logic [SEL_W-1:0] sel,
    output logic             clk_gate_en,
    output logic             sel_ack,
    output logic             sel_err,
    output logic             busy
);

    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_OFF_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] tgt_q, tgt_d;
    logic             gate_q, gate_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             pend_err_q, pend_err_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    phy_clk_sel_cnt #(
        .RST_VAL (SETTLE_LD)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        tgt_d        = tgt_q;
        gate_d       = gate_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        pend_err_d   = pend_err_q;
        cnt_load     = 1'b0;
        cnt_load_val = SETTLE_LD;
        cnt_dec      = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    gate_d  = 1'b1;
                end
            end

            ST_IDLE: begin
                // ack_q high means this is the cycle straight after an ack;
                // the requester's still-high valid belongs to the old request.
                if (sel_req_vld && !ack_q) begin
                    if (!clk_ok[sel_req]) begin
                        state_d    = ST_ACK;
                        pend_err_d = 1'b1;
                    end else if (sel_req == sel_q) begin
                        state_d    = ST_ACK;
                        pend_err_d = 1'b0;
                    end else begin
                        state_d      = ST_GATE_OFF;
                        tgt_d        = sel_req;
                        gate_d       = 1'b0;
                        pend_err_d   = 1'b0;
                        cnt_load     = 1'b1;
                        cnt_load_val = GATE_LD;
                    end
                end
            end

            ST_GATE_OFF: begin
                cnt_dec = 1'b1;
                if (!clk_ok[tgt_q]) pend_err_d = 1'b1;
                if (cnt_zero) state_d = ST_SWITCH;
            end

            ST_SWITCH: begin
                // Gate is already off here, so moving the mux cannot glitch.
                sel_d        = tgt_q;
                cnt_load     = 1'b1;
                cnt_load_val = SETTLE_LD;
                state_d      = ST_SETTLE;
                if (!clk_ok[tgt_q]) pend_err_d = 1'b1;
            end

            ST_SETTLE: begin
                cnt_dec = 1'b1;
                if (!clk_ok[tgt_q]) pend_err_d = 1'b1;
                if (cnt_zero) begin
                    gate_d  = 1'b1;
                    state_d = ST_ACK;
                end
            end

            ST_ACK: begin
                ack_d   = 1'b1;
                err_d   = pend_err_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            sel_q      <= DEFAULT_SEL;
            tgt_q      <= DEFAULT_SEL;
            gate_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            pend_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            tgt_q      <= tgt_d;
            gate_q     <= gate_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            pend_err_q <= pend_err_d;
        end
    end

    assign sel         = sel_q;
    assign clk_gate_en = gate_q;
    assign sel_ack     = ack_q;
    assign sel_err     = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_phy_clk_sel_seq.sv
// Scoreboard bench for the clock-select sequencer with a timing-rule reference model.
// Latency: n/a.
// Backpressure: requester holds valid until ack, as a real client would.
module tb_phy_clk_sel_seq;

    localparam int G  = 4;
    localparam int ST = 8;
    localparam logic [1:0] DEF = 2'd0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sel_req_vld = 1'b0;
    logic [1:0] sel_req = 2'd0;
    logic [3:0] clk_ok = 4'hF;
    logic [1:0] sel;
    logic       clk_gate_en;
    logic       sel_ack;
    logic       sel_err;
    logic       busy;

    phy_clk_sel_seq #(
        .GATE_OFF_CYC (G),
        .SETTLE_CYC   (ST),
        .DEFAULT_SEL  (DEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sel_req_vld (sel_req_vld),
        .sel_req     (sel_req),
        .clk_ok      (clk_ok),
        .sel         (sel),
        .clk_gate_en (clk_gate_en),
        .sel_ack     (sel_ack),
        .sel_err     (sel_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         ack_cyc;
        logic       err;
        logic [1:0] sel;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   acks_seen = 0;

    // Expected-behaviour window of the current/last transaction.
    bit         win_en = 0;
    int         w_lo_f = 1, w_lo_t = 0, w_sel_at = 0;
    logic [1:0] w_sel_old = DEF, w_sel_new = DEF;

    logic [1:0] cur = DEF;      // model of the applied select
    bit         held = 0;
    int         held_s = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: ack scoreboard, per-cycle gate/sel window, glitch-free select rule.
    logic [1:0] prev_sel = DEF;
    logic       prev_gate = 1'b0;
    logic       prev_rst = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (sel_ack === 1'b1) begin
            acks_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_cyc", cyc, e.ack_cyc);
                chk("ack_err", sel_err, e.err);
                chk("ack_sel", sel, e.sel);
            end
        end else if (sel_err === 1'b1) begin
            chk("err_without_ack", 1, 0);
        end
        if (!reset && !prev_rst) begin
            if (win_en) begin
                chk("gate_win", clk_gate_en, !(cyc >= w_lo_f && cyc <= w_lo_t));
                chk("sel_win", sel, (cyc >= w_sel_at) ? w_sel_new : w_sel_old);
            end
            if (sel !== prev_sel) begin
                chk("sel_move_gate_now", clk_gate_en, 0);
                chk("sel_move_gate_prev", prev_gate, 0);
            end
        end
        prev_sel  = sel;
        prev_gate = clk_gate_en;
        prev_rst  = reset;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        sel_req_vld = 1'b0;
        held = 0;
        win_en = 0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_sel", sel, DEF);
        chk("rst_gate", clk_gate_en, 0);
        chk("rst_ack", sel_ack, 0);
        chk("rst_err", sel_err, 0);
        chk("rst_busy", busy, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        // Gate held low for 8 cycles counted from the last reset edge, then high.
        for (int k = 0; k <= ST; k++) begin
            @(negedge clk);
            chk("init_gate", clk_gate_en, (k == ST));
            chk("init_busy", busy, (k != ST));
            chk("init_sel", sel, DEF);
        end
        cur = DEF;
    endtask

    // Issue one request; the expected ack cycle, error and select are derived
    // from the sampling cycle s with the published timing rules.
    task automatic do_req(input logic [1:0] r, input logic [3:0] ok, input bit drop, input bit keep);
        int         s, a;
        logic       e;
        logic [1:0] ns;
        bit         sw, got;
        exp_t       x;
        if (held) begin
            s = held_s;
            held = 0;
        end else begin
            @(posedge clk); #1;
            clk_ok = ok;
            sel_req = r;
            sel_req_vld = 1'b1;
            s = cyc + 1;
        end
        sw = 0;
        if (!clk_ok[r]) begin
            a = s + 1; e = 1'b1; ns = cur;
        end else if (r == cur) begin
            a = s + 1; e = 1'b0; ns = cur;
        end else begin
            sw = 1; a = s + G + ST + 2; e = drop; ns = r;
        end
        x.ack_cyc = a; x.err = e; x.sel = ns;
        exp_q.push_back(x);
        w_lo_f    = sw ? s : 1;
        w_lo_t    = sw ? s + G + ST : 0;
        w_sel_old = cur;
        w_sel_new = ns;
        w_sel_at  = s + G + 1;
        win_en    = 1;
        got = 0;
        for (int i = 0; i < G + ST + 20 && !got; i++) begin
            @(negedge clk);
            if (sel_ack === 1'b1) begin
                got = 1;
            end else if (sw) begin
                if (cyc > s) sel_req = 2'($urandom);
                if (drop && cyc == s + 5) clk_ok[r] = 1'b0;
                if (drop && cyc == s + 8) clk_ok[r] = 1'b1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no sel_ack, expected at cyc %0d", a);
        end
        cur = ns;
        if (keep) begin
            held = 1;
            held_s = cyc + 2;
        end else begin
            @(posedge clk); #1;
            sel_req_vld = 1'b0;
        end
    endtask

    initial begin
        int         s, nack;
        logic [1:0] r;
        logic [3:0] ok;

        do_reset();
        do_req(2'd2, 4'hF, 0, 0);        // real switch 0 -> 2
        do_req(2'd3, 4'b0111, 0, 0);     // dead source, rejected
        do_req(2'd2, 4'hF, 0, 0);        // already selected, no gating
        do_req(2'd1, 4'hF, 1, 0);        // target dies mid-sequence
        do_req(2'd3, 4'b0111, 0, 1);     // valid held past the ack ...
        do_req(2'd3, 4'b0111, 0, 0);     // ... becomes a second request

        // Reset during SETTLE aborts without an ack.
        @(posedge clk); #1;
        r = cur + 2'd1;
        clk_ok = 4'hF;
        sel_req = r;
        sel_req_vld = 1'b1;
        s = cyc + 1;
        win_en = 0;
        for (int i = 0; i < 40 && cyc < s + 8; i++) @(negedge clk);
        chk("abort_busy", busy, 1);
        chk("abort_gate", clk_gate_en, 0);
        nack = acks_seen;
        do_reset();
        chk("abort_no_ack", acks_seen, nack);

        for (int t = 0; t < 40; t++) begin
            ok = 4'($urandom);
            r  = 2'($urandom);
            if ($urandom_range(0, 3) != 0) ok[r] = 1'b1;
            do_req(r, ok, ($urandom_range(0, 3) == 0), 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule

// File: doc/phy_clk_sel_seq.md
PHY_CLK_SEL_SEQ -- requirements
Module: phy_clk_sel_seq

Interface
REQ-001 Parameter GATE_OFF_CYC, default 4: cycles clk_gate_en stays low before sel changes; legal range 1..255.
REQ-002 Parameter SETTLE_CYC, default 8: cycles after sel changes before clk_gate_en re-asserts; legal range 1..255.
REQ-003 Parameter DEFAULT_SEL, default 2'd0: sel value driven out of reset.
REQ-004 clk  input  1  free-running always-on reference clock; the only clock in the block.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sel_req_vld  input  1  request valid; level, held high by requester until sel_ack.
REQ-007 sel_req  input  2  requested clock source index; stable while sel_req_vld is high.
REQ-008 clk_ok  input  4  per-source alive flags, already synchronised to clk; bit n qualifies source n.
REQ-009 sel  output  2  registered select to the downstream 4:1 clock mux.
REQ-010 clk_gate_en  output  1  registered enable to the ICG after the mux.
REQ-011 sel_ack  output  1  one-cycle completion pulse.
REQ-012 sel_err  output  1  one-cycle pulse, coincident with sel_ack, when the request was rejected.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states INIT, IDLE, GATE_OFF, SWITCH, SETTLE, ACK.
REQ-015 INIT: clk_gate_en=0, load counter with SETTLE_CYC, decrement each cycle, go to IDLE when the counter reaches 0, asserting clk_gate_en on IDLE entry.
REQ-016 IDLE: sample sel_req_vld each cycle; requests are sampled only in IDLE.
REQ-017 IDLE with sel_req_vld=1 and clk_ok[sel_req]=0 -> ACK with sel_err; sel and clk_gate_en unchanged.
REQ-018 IDLE with sel_req_vld=1 and sel_req==sel (source ok) -> ACK without gating; sel_err=0.
REQ-019 IDLE with sel_req_vld=1, sel_req!=sel, clk_ok[sel_req]=1 -> capture sel_req into an internal target register, clk_gate_en=0, load counter GATE_OFF_CYC, enter GATE_OFF.
REQ-020 GATE_OFF: decrement; at counter 0 enter SWITCH.
REQ-021 SWITCH: sel<=target for exactly one cycle, load counter SETTLE_CYC, enter SETTLE.
REQ-022 SETTLE: decrement; at counter 0 set clk_gate_en=1, enter ACK.
REQ-023 ACK: sel_ack=1 for one cycle, then IDLE; the requester drops sel_req_vld after the ack, and the block ignores sel_req_vld in the cycle after ACK. A request held high into that cycle is treated as a new request one cycle later.
REQ-024 Latency for a real switch: sel changes GATE_OFF_CYC+1 cycles after request sampling; sel_ack fires GATE_OFF_CYC+SETTLE_CYC+2 cycles after sampling.
REQ-025 clk_ok deasserting for the target during GATE_OFF/SETTLE SHALL NOT abort the sequence; the switch completes, then sel_err pulses with sel_ack.
REQ-026 Counter: 8-bit down-counter; loaded values are parameters, never 0.
REQ-027 sel SHALL change only in SWITCH and only while clk_gate_en=0.
REQ-028 sel_req changes while busy SHALL have no effect; the target register is frozen after capture.

Reset
REQ-029 Reset SHALL force state=INIT, sel=DEFAULT_SEL, clk_gate_en=0, sel_ack=0, sel_err=0, busy=1, counter=SETTLE_CYC.
REQ-030 Reset asserted mid-sequence SHALL abort immediately with no ack; the next cycle after release begins INIT.

Structure
REQ-031 Package phy_clk_sel_pkg SHALL hold the FSM state enum, the counter width constant (8) and the select width constant (2).
REQ-032 A sub-module phy_clk_sel_cnt (loadable 8-bit down-counter with zero flag) SHALL be instantiated once.
REQ-033 All outputs SHALL be driven directly from flops, with no combinational path from input to output.

Verification
REQ-034 Reset release, defaults -> clk_gate_en=0 for 8 cycles, then 1; sel=0; busy drops with IDLE.
REQ-035 Request 2'd2, clk_ok=4'hF -> clk_gate_en falls the next cycle; sel=2 five cycles after sampling; sel_ack at cycle 14; sel_err=0.
REQ-036 Request 2'd3, clk_ok=4'b0111 -> sel_ack and sel_err pulse together two cycles after request; sel and clk_gate_en unchanged.
REQ-037 Request equal to current sel -> sel_ack two cycles after request; clk_gate_en never falls.
REQ-038 Reset pulsed during SETTLE -> no sel_ack; sel=DEFAULT_SEL; INIT sequence repeats.
REQ-039 sel_req toggled while busy, plus a random-request soak -> assertion that sel changes only when clk_gate_en=0, with the captured target applied.
